// File: rtl/gravity_divider_pkg.sv
// rtl/gravity_divider_pkg.sv - shared widths, thresholds and state encoding for the centroid divider
package gravity_divider_pkg;

  localparam int SUM_S_WIDTH  = 20;
  localparam int SUM_SX_WIDTH = 28;
  localparam int COORD_WIDTH  = 11;
  localparam int MIN_MASS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gravity_divider_if.sv
// rtl/gravity_divider_if.sv - valid/ready result bus towards the output stage
interface gravity_divider_if #(
  parameter int COORD_WIDTH = gravity_divider_pkg::COORD_WIDTH
);

  logic                   oVALID;
  logic                   iREADY;
  logic [COORD_WIDTH-1:0] oX;
  logic [COORD_WIDTH-1:0] oY;
  logic                   oFOUND;

  modport master (output oVALID, output oX, output oY, output oFOUND, input iREADY);
  modport slave  (input oVALID, input oX, input oY, input oFOUND, output iREADY);

endinterface

// File: rtl/gravity_divider_seq_divider.sv
// rtl/gravity_divider_seq_divider.sv - restoring divider, one quotient bit per step, MSB first
module gravity_divider_seq_divider #(
  parameter int DVD_W = 28,
  parameter int DVR_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVR_W:0]   remainder,
  output logic             done
);

  // The dividend register shifts out dividend bits at the top and takes
  // quotient bits in at the bottom, so after DVD_W steps it holds the quotient.
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DVR_W:0]   rem_q, rem_d;
  logic [DVR_W-1:0] dvr_q, dvr_d;
  logic [DVR_W:0]   trial;

  // Load operands on start, otherwise perform one restoring step when enabled
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvr_d  = dvr_q;
    trial  = {rem_q[DVR_W-1:0], quot_q[DVD_W-1]};
    if (start) begin
      quot_d = dividend;
      rem_d  = '0;
      dvr_d  = divisor;
    end else if (step) begin
      if (trial >= {1'b0, dvr_q}) begin
        rem_d  = trial - {1'b0, dvr_q};
        quot_d = {quot_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d  = trial;
        quot_d = {quot_q[DVD_W-2:0], 1'b0};
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvr_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvr_q  <= dvr_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = step & last;

endmodule

// File: rtl/gravity_divider.sv
// rtl/gravity_divider.sv - captures S/SX/SY on trigger edge and divides them into a saturated centroid
module gravity_divider
  import gravity_divider_pkg::*;
#(
  parameter int SUM_S_WIDTH  = gravity_divider_pkg::SUM_S_WIDTH,
  parameter int SUM_SX_WIDTH = gravity_divider_pkg::SUM_SX_WIDTH,
  parameter int COORD_WIDTH  = gravity_divider_pkg::COORD_WIDTH,
  parameter int MIN_MASS     = gravity_divider_pkg::MIN_MASS
) (
  input  logic                    CCLK,
  input  logic                    RST_N,
  input  logic                    iSTART_TRIG,
  input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
  input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
  input  logic [SUM_SX_WIDTH-1:0] iSUM_SY,
  output logic                    oBUSY,
  output logic [1:0]              oSTATE,
  gravity_divider_if.master       res
);

  localparam int CNT_W = $clog2(SUM_SX_WIDTH);

  state_e           state_q, state_d;
  logic             trig_q, trig_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             trig_rise;
  logic             load;
  logic             step;
  logic             last_step;
  logic             done_x;
  logic             done_y_unused;

  logic [SUM_SX_WIDTH-1:0] quot_x, quot_y;
  logic [SUM_S_WIDTH:0]    rem_x_unused, rem_y_unused;
  logic [COORD_WIDTH-1:0]  sat_x, sat_y;

  assign trig_rise = iSTART_TRIG & ~trig_q;
  assign last_step = (cnt_q == CNT_W'(SUM_SX_WIDTH - 1));

  // Next-state logic; the edge detector follows the input in every state so
  // a trigger held high through DIV/DONE cannot fire again on return to IDLE
  always_comb begin
    state_d = state_q;
    trig_d  = iSTART_TRIG;
    found_d = found_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          load  = 1'b1;
          cnt_d = '0;
          if (iSUM_S >= SUM_S_WIDTH'(MIN_MASS)) begin
            found_d = 1'b1;
            state_d = ST_DIV;
          end else begin
            found_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (done_x) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res.iREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
    end
  end

  gravity_divider_seq_divider #(.DVD_W(SUM_SX_WIDTH), .DVR_W(SUM_S_WIDTH)) u_div_x (
    .clk(CCLK), .rst_n(RST_N), .start(load), .step(step), .last(last_step),
    .dividend(iSUM_SX), .divisor(iSUM_S),
    .quotient(quot_x), .remainder(rem_x_unused), .done(done_x)
  );

  gravity_divider_seq_divider #(.DVD_W(SUM_SX_WIDTH), .DVR_W(SUM_S_WIDTH)) u_div_y (
    .clk(CCLK), .rst_n(RST_N), .start(load), .step(step), .last(last_step),
    .dividend(iSUM_SY), .divisor(iSUM_S),
    .quotient(quot_y), .remainder(rem_y_unused), .done(done_y_unused)
  );

  // Clamp quotients that do not fit the coordinate width to all-ones
  always_comb begin
    sat_x = (|quot_x[SUM_SX_WIDTH-1:COORD_WIDTH]) ? {COORD_WIDTH{1'b1}} : quot_x[COORD_WIDTH-1:0];
    sat_y = (|quot_y[SUM_SX_WIDTH-1:COORD_WIDTH]) ? {COORD_WIDTH{1'b1}} : quot_y[COORD_WIDTH-1:0];
  end

  // Outputs decode from registered state; dividers are frozen in DONE so
  // coordinates stay stable until the result is consumed
  always_comb begin
    oBUSY      = (state_q == ST_DIV) || (state_q == ST_DONE);
    oSTATE     = state_q;
    res.oVALID = (state_q == ST_DONE);
    res.oFOUND = (state_q == ST_DONE) && found_q;
    res.oX     = ((state_q == ST_DONE) && found_q) ? sat_x : '0;
    res.oY     = ((state_q == ST_DONE) && found_q) ? sat_y : '0;
  end

endmodule

// File: tb/tb_gravity_divider.sv
// tb/tb_gravity_divider.sv - directed self-checking bench for gravity_divider
module tb_gravity_divider;

  logic        CCLK;
  logic        RST_N;
  logic        iSTART_TRIG;
  logic [19:0] iSUM_S;
  logic [27:0] iSUM_SX;
  logic [27:0] iSUM_SY;
  logic        oBUSY;
  logic [1:0]  oSTATE;

  int n_checks;
  int n_fail;

  gravity_divider_if #(.COORD_WIDTH(11)) res_if ();

  gravity_divider dut (
    .CCLK(CCLK), .RST_N(RST_N), .iSTART_TRIG(iSTART_TRIG),
    .iSUM_S(iSUM_S), .iSUM_SX(iSUM_SX), .iSUM_SY(iSUM_SY),
    .oBUSY(oBUSY), .oSTATE(oSTATE), .res(res_if.master)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CCLK);
      #1;
    end
  endtask

  // Presents operands and a rising trigger; returns just after edge k
  task automatic trigger(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy);
    iSUM_S = s;
    iSUM_SX = sx;
    iSUM_SY = sy;
    iSTART_TRIG = 1'b1;
    step(1);
    iSUM_S = '0;
    iSUM_SX = '0;
    iSUM_SY = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_if.oVALID !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
  endtask

  task automatic consume();
    res_if.iREADY = 1'b1;
    step(1);
    res_if.iREADY = 1'b0;
    iSTART_TRIG = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step(3);
    n_checks++; if (oBUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBUSY); end
    n_checks++; if (res_if.oVALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_if.oVALID); end
    n_checks++; if (res_if.oX !== 11'd0 || res_if.oY !== 11'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", res_if.oX, res_if.oY); end
    n_checks++; if (res_if.oFOUND !== 1'b0) begin n_fail++; $display("FAIL reset_found: got %b expected 0", res_if.oFOUND); end
    n_checks++; if (oSTATE !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", oSTATE); end
    RST_N = 1'b1;
    step(2);
  endtask

  task automatic test_full_frame();
    int n;
    trigger(20'd307200, 28'd98150400, 28'd73574400);
    n_checks++; if (oBUSY !== 1'b1 || oSTATE !== 2'd1) begin n_fail++; $display("FAIL full_busy: got busy=%b state=%0d expected 1,1", oBUSY, oSTATE); end
    wait_valid(n);
    n_checks++; if (n !== 28) begin n_fail++; $display("FAIL full_latency: got %0d expected 28", n); end
    n_checks++; if (res_if.oX !== 11'd319 || res_if.oY !== 11'd239) begin n_fail++; $display("FAIL full_xy: got %0d,%0d expected 319,239", res_if.oX, res_if.oY); end
    n_checks++; if (res_if.oFOUND !== 1'b1) begin n_fail++; $display("FAIL full_found: got %b expected 1", res_if.oFOUND); end
    consume();
    n_checks++; if (oBUSY !== 1'b0 || oSTATE !== 2'd0) begin n_fail++; $display("FAIL full_release: got busy=%b state=%0d expected 0,0", oBUSY, oSTATE); end
  endtask

  task automatic test_exact_centre();
    int n;
    res_if.iREADY = 1'b1;
    trigger(20'd100, 28'd32000, 28'd24000);
    wait_valid(n);
    n_checks++; if (n !== 28) begin n_fail++; $display("FAIL centre_latency: got %0d expected 28", n); end
    n_checks++; if (res_if.oX !== 11'd320 || res_if.oY !== 11'd240) begin n_fail++; $display("FAIL centre_xy: got %0d,%0d expected 320,240", res_if.oX, res_if.oY); end
    step(1);
    n_checks++; if (res_if.oVALID !== 1'b0 || oBUSY !== 1'b0) begin n_fail++; $display("FAIL centre_one_cycle: got valid=%b busy=%b expected 0,0", res_if.oVALID, oBUSY); end
    res_if.iREADY = 1'b0;
    iSTART_TRIG = 1'b0;
    step(1);
  endtask

  task automatic test_threshold();
    logic [19:0] s_tab [3] = '{20'd0, 20'd15, 20'd16};
    logic [10:0] x_tab [3] = '{11'd0, 11'd0, 11'd1};
    logic [10:0] y_tab [3] = '{11'd0, 11'd0, 11'd2};
    logic        f_tab [3] = '{1'b0, 1'b0, 1'b1};
    int          l_tab [3] = '{0, 0, 28};
    int n;
    for (int i = 0; i < 3; i++) begin
      trigger(s_tab[i], 28'd16, 28'd32);
      wait_valid(n);
      n_checks++; if (n !== l_tab[i]) begin n_fail++; $display("FAIL thr_latency[%0d]: got %0d expected %0d", i, n, l_tab[i]); end
      n_checks++; if (res_if.oX !== x_tab[i] || res_if.oY !== y_tab[i]) begin n_fail++; $display("FAIL thr_xy[%0d]: got %0d,%0d expected %0d,%0d", i, res_if.oX, res_if.oY, x_tab[i], y_tab[i]); end
      n_checks++; if (res_if.oFOUND !== f_tab[i]) begin n_fail++; $display("FAIL thr_found[%0d]: got %b expected %b", i, res_if.oFOUND, f_tab[i]); end
      consume();
    end
  endtask

  task automatic test_saturation();
    int n;
    trigger(20'd16, 28'hFFF_FFFF, 28'd32);
    wait_valid(n);
    n_checks++; if (res_if.oX !== 11'd2047 || res_if.oY !== 11'd2) begin n_fail++; $display("FAIL sat_xy: got %0d,%0d expected 2047,2", res_if.oX, res_if.oY); end
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    trigger(20'd100, 28'd32000, 28'd24000);
    wait_valid(n);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) iSTART_TRIG = 1'b0;
      if (i == 20) iSTART_TRIG = 1'b1;
      step(1);
      if (oBUSY !== 1'b1 || res_if.oVALID !== 1'b1 || res_if.oX !== 11'd320 || res_if.oY !== 11'd240 || oSTATE !== 2'd2) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    res_if.iREADY = 1'b1;
    step(1);
    res_if.iREADY = 1'b0;
    n_checks++; if (oBUSY !== 1'b0 || oSTATE !== 2'd0) begin n_fail++; $display("FAIL bp_release: got busy=%b state=%0d expected 0,0", oBUSY, oSTATE); end
    step(5);
    n_checks++; if (oBUSY !== 1'b0 || oSTATE !== 2'd0) begin n_fail++; $display("FAIL bp_no_retrigger: got busy=%b state=%0d expected 0,0", oBUSY, oSTATE); end
    iSTART_TRIG = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid_div();
    int n;
    trigger(20'd100, 28'd32000, 28'd24000);
    step(10);
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++; if (oBUSY !== 1'b0 || res_if.oVALID !== 1'b0 || oSTATE !== 2'd0) begin n_fail++; $display("FAIL mid_reset_ctrl: got busy=%b valid=%b state=%0d expected 0,0,0", oBUSY, res_if.oVALID, oSTATE); end
    n_checks++; if (res_if.oX !== 11'd0 || res_if.oY !== 11'd0 || res_if.oFOUND !== 1'b0) begin n_fail++; $display("FAIL mid_reset_data: got %0d,%0d,%b expected 0,0,0", res_if.oX, res_if.oY, res_if.oFOUND); end
    iSTART_TRIG = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(2);
    trigger(20'd100, 28'd32000, 28'd24000);
    wait_valid(n);
    n_checks++; if (n !== 28) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 28", n); end
    n_checks++; if (res_if.oX !== 11'd320 || res_if.oY !== 11'd240 || res_if.oFOUND !== 1'b1) begin n_fail++; $display("FAIL post_reset_xy: got %0d,%0d,%b expected 320,240,1", res_if.oX, res_if.oY, res_if.oFOUND); end
    consume();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    RST_N = 1'b0;
    iSTART_TRIG = 1'b0;
    iSUM_S = '0;
    iSUM_SX = '0;
    iSUM_SY = '0;
    res_if.iREADY = 1'b0;
    #1;
    test_reset();
    test_full_frame();
    test_exact_centre();
    test_threshold();
    test_saturation();
    test_backpressure();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
